// File: rtl/tft_bus_arbiter_pkg.sv
// Shared definitions for the TFT bus arbiter.
//   arb_state_e : arbiter FSM state encoding
//   ARB_ID_W()  : width of a client index for a given client count
package tft_arb_pkg;

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    IDLE    = 3'd1,
    ARM     = 3'd2,
    RUN     = 3'd3,
    DRAIN   = 3'd4,
    RELEASE = 3'd5
  } arb_state_e;

  // Client index width; a single client still needs one bit.
  function automatic int ARB_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tft_bus_arbiter_rr_pick.sv
// Round-robin picker, purely combinational.
//   req_i    : N-bit request vector
//   start_i  : index that gets first priority (must be < N)
//   valid_o  : at least one request is set
//   winner_o : first set request at or after start_i, wrapping past N-1
module rr_pick
  import tft_arb_pkg::*;
#(
  parameter  int N    = 3,
  localparam int ID_W = ARB_ID_W(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] start_i,
  output logic            valid_o,
  output logic [ID_W-1:0] winner_o
);

  // Scan offsets from farthest to nearest so the nearest set request overwrites the rest.
  always_comb begin
    int              sum;
    logic [ID_W-1:0] idx;
    sum      = 0;
    idx      = '0;
    valid_o  = 1'b0;
    winner_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum      = int'(start_i) + k;
      idx      = (sum >= N) ? ID_W'(sum - N) : ID_W'(sum);
      valid_o  = valid_o | req_i[idx];
      winner_o = req_i[idx] ? idx : winner_o;
    end
  end

endmodule

// File: rtl/tft_bus_arbiter.sv
// Arbiter sharing one tft_spi byte transmitter between N drawing clients.
// Boots client 0 (init) once after reset, then serves queued redraw requests
// round-robin, one session at a time, and muxes the granted client onto the SPI.
//   clk, rst            : clock, synchronous active-low reset
//   req_i               : per-client request pulses (queued in pend)
//   client_busy_i       : per-client busy (high while drawing)
//   client_data_i       : per-client byte, client i at [8i+7:8i]
//   client_dc_i         : per-client data/command select
//   client_transmit_i   : per-client byte strobe
//   client_enable_o     : one-hot or zero enable to the granted client
//   spi_busy_i          : tft_spi busy
//   spi_data_o/dc_o/transmit_o : muxed SPI inputs
//   grant_valid_o       : a client holds the bus (ARM/RUN/DRAIN)
//   grant_id_o          : holding or last-granted client
//   init_done_o         : sticky, first client-0 session finished
//   arm_err_o           : sticky, a granted client never raised busy
module tft_bus_arbiter
  import tft_arb_pkg::*;
#(
  parameter  int N_CLIENTS   = 3,
  parameter  int ARM_TIMEOUT = 15,
  localparam int ID_W        = ARB_ID_W(N_CLIENTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CLIENTS-1:0]   req_i,
  input  logic [N_CLIENTS-1:0]   client_busy_i,
  input  logic [8*N_CLIENTS-1:0] client_data_i,
  input  logic [N_CLIENTS-1:0]   client_dc_i,
  input  logic [N_CLIENTS-1:0]   client_transmit_i,
  output logic [N_CLIENTS-1:0]   client_enable_o,
  input  logic                   spi_busy_i,
  output logic [7:0]             spi_data_o,
  output logic                   spi_dc_o,
  output logic                   spi_transmit_o,
  output logic                   grant_valid_o,
  output logic [ID_W-1:0]        grant_id_o,
  output logic                   init_done_o,
  output logic                   arm_err_o
);

  localparam int                   CNT_W   = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     CNT_TOP = CNT_W'(ARM_TIMEOUT - 1);
  localparam logic [ID_W-1:0]      LAST_ID = ID_W'(N_CLIENTS - 1);
  localparam logic [N_CLIENTS-1:0] BIT0    = {{(N_CLIENTS-1){1'b0}}, 1'b1};

  arb_state_e             state_q, state_d;
  logic [N_CLIENTS-1:0]   pend_q, pend_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   init_done_q, init_done_d;
  logic                   arm_err_q, arm_err_d;

  logic [N_CLIENTS-1:0]   clr_s;
  logic [N_CLIENTS-1:0]   pick_req_s;
  logic                   pick_valid_s;
  logic [ID_W-1:0]        pick_id_s;
  logic                   busy_g_s;
  logic                   holding_s;

  // Until the boot session has finished only a re-init request may win.
  assign pick_req_s = init_done_q ? pend_q : (pend_q & BIT0);
  assign busy_g_s   = client_busy_i[grant_q];

  rr_pick #(
    .N (N_CLIENTS)
  ) u_rr_pick (
    .req_i    (pick_req_s),
    .start_i  (rr_ptr_q),
    .valid_o  (pick_valid_s),
    .winner_o (pick_id_s)
  );

  // State register and arbiter bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= BOOT;
      pend_q      <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= ID_W'(1);
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      arm_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      arm_err_q   <= arm_err_d;
    end
  end

  // Next-state logic: grant selection, session tracking, sticky flags.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    arm_err_d   = arm_err_q;
    clr_s       = '0;
    case (state_q)
      BOOT: begin
        state_d = ARM;
        grant_d = '0;
        cnt_d   = '0;
        clr_s   = BIT0;
      end
      IDLE: begin
        if (pick_valid_s) begin
          state_d  = ARM;
          grant_d  = pick_id_s;
          rr_ptr_d = (pick_id_s == LAST_ID) ? '0 : pick_id_s + ID_W'(1);
          cnt_d    = '0;
          clr_s    = BIT0 << pick_id_s;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        // Busy on the last counted cycle still counts as a successful arm.
        if (busy_g_s) begin
          state_d = RUN;
        end else if (cnt_q == CNT_TOP) begin
          state_d   = RELEASE;
          arm_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!busy_g_s) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // Hold the grant until the final byte has left the wire.
        if (!spi_busy_i) begin
          state_d = RELEASE;
        end else begin
          state_d = DRAIN;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        if (grant_q == '0) begin
          init_done_d = 1'b1;
        end else begin
          init_done_d = init_done_q;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    // A request arriving on its own grant cycle is re-queued (set wins).
    pend_d = (pend_q & ~clr_s) | req_i;
  end

  // Output decode: enables and SPI mux follow the registered grant.
  always_comb begin
    holding_s = (state_q == ARM) || (state_q == RUN) || (state_q == DRAIN);
    if (holding_s) begin
      client_enable_o = BIT0 << grant_q;
      spi_data_o      = client_data_i[{grant_q, 3'b000} +: 8];
      spi_dc_o        = client_dc_i[grant_q];
      spi_transmit_o  = client_transmit_i[grant_q];
    end else begin
      client_enable_o = '0;
      spi_data_o      = 8'h00;
      spi_dc_o        = 1'b0;
      spi_transmit_o  = 1'b0;
    end
    grant_valid_o = holding_s;
    grant_id_o    = grant_q;
    init_done_o   = init_done_q;
    arm_err_o     = arm_err_q;
  end

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Directed bench for tft_bus_arbiter (3 clients, 15-cycle arm timeout).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_tft_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_i;
  logic [2:0]  client_busy_i;
  logic [23:0] client_data_i;
  logic [2:0]  client_dc_i;
  logic [2:0]  client_transmit_i;
  logic [2:0]  client_enable_o;
  logic        spi_busy_i;
  logic [7:0]  spi_data_o;
  logic        spi_dc_o;
  logic        spi_transmit_o;
  logic        grant_valid_o;
  logic [1:0]  grant_id_o;
  logic        init_done_o;
  logic        arm_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_byte [3];
  logic [2:0] dc_pat;
  logic [2:0] tx_pat;

  tft_bus_arbiter #(
    .N_CLIENTS   (3),
    .ARM_TIMEOUT (15)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_i             (req_i),
    .client_busy_i     (client_busy_i),
    .client_data_i     (client_data_i),
    .client_dc_i       (client_dc_i),
    .client_transmit_i (client_transmit_i),
    .client_enable_o   (client_enable_o),
    .spi_busy_i        (spi_busy_i),
    .spi_data_o        (spi_data_o),
    .spi_dc_o          (spi_dc_o),
    .spi_transmit_o    (spi_transmit_o),
    .grant_valid_o     (grant_valid_o),
    .grant_id_o        (grant_id_o),
    .init_done_o       (init_done_o),
    .arm_err_o         (arm_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_enable"}, 32'(client_enable_o), 32'd0);
    check({tag, "_valid"}, 32'(grant_valid_o), 32'd0);
    check({tag, "_spi_data"}, 32'(spi_data_o), 32'd0);
    check({tag, "_spi_dc"}, 32'(spi_dc_o), 32'd0);
    check({tag, "_spi_tx"}, 32'(spi_transmit_o), 32'd0);
  endtask

  // Entered just after the edge that moved the arbiter into ARM for client id.
  // Drives busy for busy_len cycles, then holds spi_busy for spi_extra cycles.
  task automatic serve(input int id, input int busy_len, input int spi_extra);
    logic [2:0] oh;
    oh = 3'b001 << id;
    check("arm_enable", 32'(client_enable_o), 32'(oh));
    check("arm_grant_id", 32'(grant_id_o), 32'(id));
    check("arm_valid", 32'(grant_valid_o), 32'd1);
    check("mux_data", 32'(spi_data_o), 32'(exp_byte[id]));
    check("mux_dc", 32'(spi_dc_o), 32'(dc_pat[id]));
    check("mux_tx", 32'(spi_transmit_o), 32'(tx_pat[id]));
    client_busy_i[id] = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      tick();
      check("run_enable", 32'(client_enable_o), 32'(oh));
    end
    client_busy_i[id] = 1'b0;
    spi_busy_i = (spi_extra > 0);
    tick();
    check("drain_enable", 32'(client_enable_o), 32'(oh));
    for (int i = 0; i < spi_extra; i++) begin
      tick();
      check("drain_hold", 32'(client_enable_o), 32'(oh));
    end
    spi_busy_i = 1'b0;
    tick();
    check_idle_outputs("release");
    check("release_grant_id", 32'(grant_id_o), 32'(id));
  endtask

  initial begin
    exp_byte[0] = 8'hA0;
    exp_byte[1] = 8'hB1;
    exp_byte[2] = 8'hC2;
    dc_pat      = 3'b101;
    tx_pat      = 3'b110;
    rst               = 1'b0;
    req_i             = 3'b000;
    client_busy_i     = 3'b000;
    client_data_i     = {exp_byte[2], exp_byte[1], exp_byte[0]};
    client_dc_i       = dc_pat;
    client_transmit_i = tx_pat;
    spi_busy_i        = 1'b0;

    // Reset state
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_grant_id", 32'(grant_id_o), 32'd0);
    check("reset_init_done", 32'(init_done_o), 32'd0);
    check("reset_arm_err", 32'(arm_err_o), 32'd0);

    // Boot: client 0 granted on the first edge after release; 1 and 2 queued meanwhile
    rst   = 1'b1;
    req_i = 3'b110;
    tick();
    req_i = 3'b000;
    check("boot_init_done", 32'(init_done_o), 32'd0);
    serve(0, 40, 0);
    check("boot_release_init_done", 32'(init_done_o), 32'd0);
    tick();
    check("boot_idle_init_done", 32'(init_done_o), 32'd1);
    check_idle_outputs("boot_idle");

    // Queued client 1 then client 2, with an idle cycle between sessions
    tick();
    serve(1, 5, 0);
    tick();
    check_idle_outputs("gap_idle");
    tick();

    // Client 2 never raises busy: 15 ARM cycles then timeout; queue client 1 meanwhile
    check("to_arm_enable", 32'(client_enable_o), 32'd4);
    check("to_arm_grant_id", 32'(grant_id_o), 32'd2);
    req_i = 3'b010;
    tick();
    req_i = 3'b000;
    check("to_arm1_enable", 32'(client_enable_o), 32'd4);
    for (int i = 2; i < 15; i++) begin
      tick();
      check("to_arm_hold", 32'(client_enable_o), 32'd4);
    end
    check("to_before_err", 32'(arm_err_o), 32'd0);
    tick();
    check("to_release_err", 32'(arm_err_o), 32'd1);
    check_idle_outputs("to_release");
    tick();
    check_idle_outputs("to_idle");
    check("to_idle_err_sticky", 32'(arm_err_o), 32'd1);
    check("to_idle_init_done", 32'(init_done_o), 32'd1);
    tick();

    // Client 1 still served; spi_busy held 10 cycles past busy fall
    serve(1, 3, 10);
    tick();
    check_idle_outputs("drain_idle");

    // req[1] pulsed again on its own grant cycle, with req[2] alongside
    req_i = 3'b010;
    tick();
    check_idle_outputs("req_latency");
    req_i = 3'b110;
    tick();
    req_i = 3'b000;
    serve(1, 2, 0);
    tick();
    tick();
    serve(2, 2, 0);
    tick();
    tick();
    check("requeue_grant_id", 32'(grant_id_o), 32'd1);
    check("requeue_enable", 32'(client_enable_o), 32'd2);

    // Reset mid-session with client 1 running
    client_busy_i[1] = 1'b1;
    tick();
    tick();
    check("run_before_rst", 32'(client_enable_o), 32'd2);
    rst = 1'b0;
    tick();
    check_idle_outputs("midrst");
    check("midrst_grant_id", 32'(grant_id_o), 32'd0);
    check("midrst_init_done", 32'(init_done_o), 32'd0);
    check("midrst_arm_err", 32'(arm_err_o), 32'd0);
    client_busy_i = 3'b000;
    rst = 1'b1;
    tick();
    check("reboot_init_done", 32'(init_done_o), 32'd0);
    serve(0, 3, 0);
    tick();
    check("reboot_idle_init_done", 32'(init_done_o), 32'd1);
    tick();
    check_idle_outputs("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
